// File: rtl/vcsr_seq.sv
// Vector CSR update (vsetvli/vsetivli) and element sequencer.
// Ports: clk/rst_n, CSR write (vcsr_wen, SEW, lmul, AVL) -> vl/vtype/rd,
//   sequence start (seq_start/seq_ready), element handshake, seq_done.
module vcsr_seq #(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vcsr_wen,
  input  logic [2:0]  SEW,
  input  logic [2:0]  lmul,
  input  logic [6:0]  AVL,
  output logic        csr_stall,
  output logic        rd_wen,
  output logic [31:0] rd_data,
  output logic [7:0]  vl,
  output logic [2:0]  vsew,
  output logic [2:0]  vlmul,
  output logic        vill,
  input  logic        seq_start,
  output logic        seq_ready,
  output logic        elem_valid,
  input  logic        elem_ready,
  output logic [7:0]  elem_idx,
  output logic        elem_last,
  output logic        seq_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [31:0] base;
  logic [31:0] vlmax;
  logic [31:0] sew_bits;
  logic [31:0] avl_w;
  logic        bad;
  logic [7:0]  new_vl;
  logic        csr_apply;
  logic        start_ok;

  always_comb begin
    base     = 32'(VLEN) >> (4'(SEW) + 4'd3);
    sew_bits = 32'd8 << SEW;
    vlmax    = '0;
    if (lmul[2])
      vlmax = base >> (4'd8 - 4'(lmul));
    else
      vlmax = base << lmul[1:0];
    bad = SEW[2]
        | (sew_bits > 32'(ELEN))
        | (lmul == 3'b100)
        | (vlmax == 32'd0);
    avl_w  = 32'(AVL);
    new_vl = (avl_w < vlmax) ? 8'(avl_w) : 8'(vlmax);
  end

  // A write only lands in IDLE; elsewhere upstream holds it.
  assign csr_apply = vcsr_wen & (state == IDLE);
  assign csr_stall = vcsr_wen & (state != IDLE);
  assign seq_ready = (state == IDLE) & ~vcsr_wen;
  assign start_ok  = seq_ready & seq_start;

  assign elem_valid = (state == RUN);
  assign elem_last  = (state == RUN) & (elem_idx == vl - 8'd1);
  assign seq_done   = (state == DONE);
  assign rd_data    = {24'b0, vl};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      vl       <= '0;
      vsew     <= '0;
      vlmul    <= '0;
      vill     <= 1'b1;
      elem_idx <= '0;
      rd_wen   <= 1'b0;
    end else begin
      rd_wen <= 1'b0;
      if (csr_apply) begin
        rd_wen <= 1'b1;
        if (bad) begin
          vill  <= 1'b1;
          vl    <= '0;
          vsew  <= '0;
          vlmul <= '0;
        end else begin
          vill  <= 1'b0;
          vl    <= new_vl;
          vsew  <= SEW;
          vlmul <= lmul;
        end
      end
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            elem_idx <= '0;
            if (!vill && vl != 8'd0)
              state <= RUN;
            else
              state <= DONE;
          end
        end
        RUN: begin
          if (elem_ready) begin
            if (elem_last)
              state <= DONE;
            else
              elem_idx <= elem_idx + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
